and_ary_sched: RTL
==================

// Module: and_ary_sched
// PURPOSE
//  Shares one combinational TREE_W-input AND-reduction tree (pairwise AND of a/b, then
//  balanced AND tree) among NREQ requesters, each submitting OP_W-bit operand pairs.
//  Arbitrates requesters round-robin and reduces each operand pair over CHUNKS cycles,
//  one TREE_W slice per cycle. Terminates early on the first all-zero slice result.
//  Returns the 1-bit reduction with requester id on a valid/ready response channel.
// PARAMETERS
//  NREQ    4   number of requesters (>=2)
//  OP_W    32  operand width per requester; OP_W % TREE_W == 0, else elaboration error
//  TREE_W  8   shared tree width; power of 2
//  derived: CHUNKS = OP_W/TREE_W; IDW = $clog2(NREQ); CW = $clog2(CHUNKS+1)
// PORTS
//  clk         in   1          clock
//  rst         in   1          synchronous active-high reset
//  req_valid   in   NREQ       per-requester request valid
//  req_ready   out  NREQ       one-hot grant/accept; at most one bit high
//  req_a       in   NREQ*OP_W  operand A, requester i at [i*OP_W +: OP_W]
//  req_b       in   NREQ*OP_W  operand B, same packing
//  rsp_valid   out  1          response valid
//  rsp_ready   in   1          response accepted by consumer
//  rsp_id      out  IDW        index of the requester that owns the response
//  rsp_d       out  1          &(a & b) over all OP_W bits
//  rsp_chunks  out  CW         number of slices evaluated (1..CHUNKS)
// BEHAVIOUR
//  - Reset: state IDLE, rr_ptr=0, rsp_valid=0, rsp_d=0, rsp_id=0, rsp_chunks=0,
//    req_ready=0. Reset in any state drops the in-flight operation; no response is issued.
//  - FSM IDLE -> EVAL -> RESP -> IDLE.
//  - IDLE: g = first i with req_valid[i], searching from rr_ptr upward and wrapping.
//    If one exists: req_ready[g]=1 combinationally, in this cycle only.
//    At the edge: latch A/B of g and id=g, set idx=0, acc=1, rr_ptr=(g+1)%NREQ, go to EVAL.
//    If none: stay in IDLE.
//  - req_ready is 0 outside IDLE. A requester holds valid and data stable until ready is seen.
//  - EVAL, one slice per cycle: t = &(A[idx*TREE_W +: TREE_W] & B[same]).
//    * t==0 or idx==CHUNKS-1: rsp_d = acc & t, rsp_chunks = idx+1, go to RESP.
//    * otherwise: acc &= t, idx++.
//  - Slices are processed LSB first.
//  - RESP: rsp_valid=1. rsp_id, rsp_d and rsp_chunks are held stable until rsp_valid & rsp_ready.
//    On that handshake: rsp_valid=0, go to IDLE. No grant is made in RESP.
//  - Latency: rsp_valid rises k edges after the accept edge, k = rsp_chunks.
//    Issue interval is k+2 cycles when rsp_ready is held high.
//  - All outputs are registered except req_ready, which is decoded from state and grant.
// STRUCTURE
//  - Package and_ary_pkg: state enum {IDLE, EVAL, RESP}, and a function that computes
//    a round-robin grant from (valid, ptr).
//  - Sub-module and_tree_w #(TREE_W): purely combinational. Pairwise AND of the a/b
//    slices, then a log2(TREE_W)-level balanced AND tree. Instantiated once; the
//    scheduler muxes the slice into it.
//  - Scheduler holds the FSM, rr_ptr, operand registers, idx, acc and the response registers.
// TESTING
//  1. Req0 only, a=b=32'hFFFFFFFF -> req_ready[0] for 1 cycle; rsp_valid 4 edges later;
//     rsp_d=1, rsp_id=0, rsp_chunks=4.
//  2. Req1, a=32'hFFFFFFFE, b=32'hFFFFFFFF -> rsp_valid 1 edge after accept;
//     rsp_d=0, rsp_id=1, rsp_chunks=1.
//  3. Req2, a=32'h7FFFFFFF, b=32'hFFFFFFFF -> rsp_d=0, rsp_chunks=4.
//  4. All four req_valid held high from reset, rsp_ready=1 -> grant order 0,1,2,3,0.
//     Never two req_ready bits high at once.
//  5. rsp_ready=0 for 3 cycles during RESP -> rsp_* stable; req_ready stays 0;
//     release -> IDLE, then next grant.
//  6. rst=1 for 1 cycle mid-EVAL on req3 -> no response; all outputs return to reset
//     values; with all requests valid, next grant goes to req0.

Source files
------------

// File: rtl/and_ary_sched_pkg.sv
// Shared types and the round-robin grant helper for the AND-reduction scheduler.
package and_ary_pkg;

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    // Upper bound on requesters the grant helper can search.
    localparam int MAX_REQ = 32;

    typedef struct packed {
        logic       found;
        logic [4:0] id;
    } grant_t;

    // First valid requester at or above ptr, wrapping past nreq-1 back to 0.
    // The scan runs from the far end down, so the nearest hit is the last one written.
    function automatic grant_t rr_grant(input logic [MAX_REQ-1:0] valid,
                                       input int nreq, input int ptr);
        grant_t g;
        int     idx;
        g = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < nreq) begin
                idx = ptr + k;
                if (idx >= nreq) idx = idx - nreq;
                if (valid[idx]) begin
                    g.found = 1'b1;
                    g.id    = 5'(idx);
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/and_ary_sched_if.sv
// Request/response bundle between requesters and the shared AND-reduction scheduler.
interface and_ary_sched_if #(
    parameter int NREQ   = 4,
    parameter int OP_W   = 32,
    parameter int TREE_W = 8
);
    localparam int CHUNKS = OP_W / TREE_W;
    localparam int IDW    = $clog2(NREQ);
    localparam int CW     = $clog2(CHUNKS + 1);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*OP_W-1:0] req_a;
    logic [NREQ*OP_W-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic                 rsp_d;
    logic [CW-1:0]        rsp_chunks;

    // Requester side.
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_d, rsp_chunks
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_d, rsp_chunks
    );
endinterface

// File: rtl/and_ary_sched_tree.sv
// Combinational TREE_W-wide reduction: pairwise AND of a/b, then a balanced AND tree.
module and_tree_w #(
    parameter int TREE_W = 8
) (
    input  logic [TREE_W-1:0] a,
    input  logic [TREE_W-1:0] b,
    output logic              y
);
    localparam int LVLS = $clog2(TREE_W);

    // Level l holds TREE_W>>l partial products; level LVLS is the single root.
    for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
        logic [(TREE_W>>l)-1:0] v;
        if (l == 0) begin : g_leaf
            assign v = a & b;
        end else begin : g_node
            for (genvar j = 0; j < (TREE_W >> l); j++) begin : g_and
                assign v[j] = g_lvl[l-1].v[2*j] & g_lvl[l-1].v[2*j+1];
            end
        end
    end

    assign y = g_lvl[LVLS].v[0];
endmodule

// File: rtl/and_ary_sched.sv
// Round-robin scheduler sharing one AND-reduction tree across NREQ requesters.
// Each accepted operand pair is reduced one slice per cycle, LSB slice first,
// stopping at the first slice that reduces to zero.
module and_ary_sched
    import and_ary_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int OP_W   = 32,
    parameter int TREE_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    and_ary_sched_if.slave bus
);
    localparam int CHUNKS = OP_W / TREE_W;
    localparam int IDW    = $clog2(NREQ);
    localparam int CW     = $clog2(CHUNKS + 1);
    localparam int IW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    if (OP_W % TREE_W != 0) begin : g_bad_op_w
        $error("and_ary_sched: OP_W must be a multiple of TREE_W");
    end
    if ((TREE_W & (TREE_W - 1)) != 0) begin : g_bad_tree_w
        $error("and_ary_sched: TREE_W must be a power of 2");
    end
    if (NREQ < 2 || NREQ > MAX_REQ) begin : g_bad_nreq
        $error("and_ary_sched: NREQ out of range");
    end

    state_t                          state, state_nxt;
    logic [IDW-1:0]                  rr_ptr, cur_id;
    logic [CHUNKS-1:0][TREE_W-1:0]   op_a, op_b;
    logic [IW-1:0]                   idx;
    logic                            acc;
    logic                            t;
    logic                            last;
    grant_t                          gnt;

    // Single shared tree; the current slice is muxed in by idx.
    and_tree_w #(.TREE_W(TREE_W)) u_tree (
        .a (op_a[idx]),
        .b (op_b[idx]),
        .y (t)
    );

    // Round-robin pick and end-of-operation detection.
    always_comb begin
        gnt  = rr_grant(MAX_REQ'(bus.req_valid), NREQ, int'(rr_ptr));
        last = (t == 1'b0) || (idx == IW'(CHUNKS - 1));
    end

    // Grant is only offered while idle, to exactly one requester.
    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && gnt.found) bus.req_ready[gnt.id[IDW-1:0]] = 1'b1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (gnt.found)     state_nxt = EVAL;
            EVAL:    if (last)          state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Operand capture, slice stepping and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr         <= '0;
            cur_id         <= '0;
            op_a           <= '0;
            op_b           <= '0;
            idx            <= '0;
            acc            <= 1'b1;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_d      <= 1'b0;
            bus.rsp_id     <= '0;
            bus.rsp_chunks <= '0;
        end else begin
            unique case (state)
                IDLE: if (gnt.found) begin
                    op_a   <= bus.req_a[int'(gnt.id)*OP_W +: OP_W];
                    op_b   <= bus.req_b[int'(gnt.id)*OP_W +: OP_W];
                    cur_id <= gnt.id[IDW-1:0];
                    idx    <= '0;
                    acc    <= 1'b1;
                    rr_ptr <= (int'(gnt.id) == NREQ - 1) ? '0 : IDW'(int'(gnt.id) + 1);
                end
                EVAL: if (last) begin
                    bus.rsp_d      <= acc & t;
                    bus.rsp_chunks <= CW'(idx) + CW'(1);
                    bus.rsp_id     <= cur_id;
                    bus.rsp_valid  <= 1'b1;
                end else begin
                    acc <= acc & t;
                    idx <= idx + IW'(1);
                end
                RESP: if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
